// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and the slave receiver.
// Holds the master state encoding, the link mode constants (mode 0,
// MSB first) and a small sizing helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    NEXT,
    HOLD
  } spi_state_e;

  // Link mode: clock idles low, data sampled on the rising edge.
  localparam bit CPOL      = 1'b0;
  localparam bit CPHA      = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Word stream between a user and the SPI master.
//   tx_data/tx_valid/tx_last : word to send, valid/ready handshake
//   tx_ready                 : master can accept a word
//   rx_data/rx_valid         : captured word, one-cycle valid pulse
// master modport: the user side that offers words.
// slave modport : the SPI master block that consumes them.
interface spi_master_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_last;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;

  modport master (
    output tx_data, tx_valid, tx_last,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, tx_last,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_phase_counter.sv
// Loadable down-counter used to time CS setup, clock half-periods and
// CS hold. Load with (length - 1); tc is high while the count is zero,
// which is the last cycle of the timed phase.
//   clk, rst : clock, synchronous active-high reset
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : phase length minus one
//   tc       : terminal count
module spi_phase_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (load)           cnt <= load_val;
    else if (cnt != '0)      cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master. Sends one WIDTH-bit word per accepted handshake,
// MSB first, capturing miso in parallel. Words stay under one chip
// select until a word flagged last completes.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : word stream (tx handshake in, rx word out)
//   spi_clk  : serial clock, idle low
//   mosi     : serial data out
//   miso     : serial data in
//   cs_n     : chip select, active low
//   busy     : high in every state but IDLE
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.slave   bus,
  output logic          spi_clk,
  output logic          mosi,
  input  logic          miso,
  output logic          cs_n,
  output logic          busy
);
  localparam int PMAX = max3(CLK_DIV, CS_SETUP, CS_HOLD);
  localparam int PW   = $clog2(PMAX + 1);
  localparam int BW   = $clog2(WIDTH + 1);

  localparam logic [PW-1:0] LD_DIV   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] LD_SETUP = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] LD_HOLD  = PW'(CS_HOLD - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  spi_state_e       state, state_nx;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0]    bit_cnt;
  logic             last_q;
  logic             tc;
  logic             load;
  logic [PW-1:0]    load_val;
  logic             accept;
  logic             shift;
  logic             word_done;

  spi_phase_counter #(.W(PW)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  assign bus.tx_ready = (state == IDLE) || (state == NEXT);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    load_val  = '0;
    accept    = 1'b0;
    shift     = 1'b0;
    word_done = 1'b0;
    unique case (state)
      IDLE: if (bus.tx_valid) begin
        accept   = 1'b1;
        state_nx = SETUP;
        load     = 1'b1;
        load_val = LD_SETUP;
      end
      SETUP: if (tc) begin
        state_nx = LOW;
        load     = 1'b1;
        load_val = LD_DIV;
      end
      LOW: if (tc) begin
        state_nx = HIGH;
        load     = 1'b1;
        load_val = LD_DIV;
      end
      HIGH: if (tc) begin
        shift = 1'b1;
        load  = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          word_done = 1'b1;
          state_nx  = last_q ? HOLD : NEXT;
          load_val  = LD_HOLD;
        end else begin
          state_nx = LOW;
          load_val = LD_DIV;
        end
      end
      NEXT: if (bus.tx_valid) begin
        // chip select is already low, so go straight to the first half-period
        accept   = 1'b1;
        state_nx = LOW;
        load     = 1'b1;
        load_val = LD_DIV;
      end
      HOLD: if (tc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they line up
  // exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n         <= 1'b1;
      spi_clk      <= 1'b0;
      mosi         <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
      sh           <= '0;
      bit_cnt      <= '0;
      last_q       <= 1'b0;
    end else begin
      cs_n         <= (state_nx == IDLE);
      spi_clk      <= (state_nx == HIGH);
      bus.rx_valid <= word_done;
      if (accept) begin
        sh      <= bus.tx_data;
        last_q  <= bus.tx_last;
        mosi    <= bus.tx_data[WIDTH-1];
        bit_cnt <= '0;
      end else if (shift) begin
        sh      <= {sh[WIDTH-2:0], miso};
        bit_cnt <= bit_cnt + 1'b1;
        // after the final bit mosi keeps the LSB instead of leaking
        // captured data onto the line
        if (!word_done) mosi <= sh[WIDTH-2];
      end
      if (word_done) bus.rx_data <= {sh[WIDTH-2:0], miso};
    end
  end
endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int SU  = 2;
  localparam int HD  = 2;

  typedef struct {
    logic [W-1:0] rx;
    int           due;
    bit           last;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vec = 0;
  int   err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: default timing, driven by a mode-0 slave model
  spi_master_if #(.WIDTH(W)) bus_a ();
  logic sclk_a, mosi_a, miso_a, cs_a, busy_a;

  spi_master #(.WIDTH(W), .CLK_DIV(DIV), .CS_SETUP(SU), .CS_HOLD(HD)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .spi_clk(sclk_a), .mosi(mosi_a),
    .miso(miso_a), .cs_n(cs_a), .busy(busy_a)
  );

  // instance B: fastest timing, mosi looped back to miso
  spi_master_if #(.WIDTH(W)) bus_b ();
  logic sclk_b, mosi_b, cs_b, busy_b;

  spi_master #(.WIDTH(W), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .spi_clk(sclk_b), .mosi(mosi_b),
    .miso(mosi_b), .cs_n(cs_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // reference model state
  rec_t         exp_q[$];
  logic [W-1:0] mosi_q[$];
  logic [W-1:0] slv_q[$];
  bit           open_cs = 0;
  bit           flush = 0;
  bit           rise_pending = 0;
  int           exp_rise = 0;
  int           rises = 0;

  // mode-0 slave: first bit valid once cs_n is low, next bit after each falling edge
  int   s_idx = 0;
  logic s_prev_clk = 1'b0;
  always @(negedge clk) begin
    if (cs_a !== 1'b0) s_idx = 0;
    else if (s_prev_clk && !sclk_a) begin
      s_idx++;
      if (s_idx == W) begin
        s_idx = 0;
        if (slv_q.size() != 0) void'(slv_q.pop_front());
      end
    end
    s_prev_clk = sclk_a;
    miso_a = (slv_q.size() != 0) ? slv_q[0][W-1-s_idx] : 1'b0;
  end

  // monitor for instance A
  logic [W-1:0] m_sh = '0;
  int           m_nb = 0;
  logic         m_prev_clk = 1'b0;
  logic         m_prev_cs = 1'b1;
  always @(negedge clk) begin
    rec_t r;
    if (flush && cs_a === 1'b1) begin
      m_nb = 0;
      flush = 0;
      rise_pending = 0;
    end else if (!rst) begin
      if (sclk_a && !m_prev_clk) begin
        rises++;
        m_sh = {m_sh[W-2:0], mosi_a};
        m_nb++;
        if (m_nb == W) begin
          m_nb = 0;
          if (mosi_q.size() != 0) chk("mosi_word", m_sh, mosi_q.pop_front());
          else chk("mosi_spurious", 1, 0);
        end
      end
      if (bus_a.rx_valid) begin
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          chk("rx_data", bus_a.rx_data, r.rx);
          chk("rx_cycle", cyc, r.due);
          if (r.last) begin
            exp_rise = cyc + HD;
            rise_pending = 1;
          end
        end else chk("rx_spurious", 1, 0);
      end
      if (cs_a && !m_prev_cs) begin
        chk("cs_rise", cyc, exp_rise);
        rise_pending = 0;
      end
    end
    m_prev_clk = sclk_a;
    m_prev_cs  = cs_a;
  end

  task automatic send(input logic [W-1:0] d, input bit last, input logic [W-1:0] sw);
    rec_t r;
    int n = 0;
    bus_a.tx_data  = d;
    bus_a.tx_last  = last;
    bus_a.tx_valid = 1'b1;
    while (!bus_a.tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus_a.tx_ready) begin
      chk("accept_timeout", 0, 1);
      bus_a.tx_valid = 1'b0;
      return;
    end
    // accepted at the coming edge: cycle 0 of this word
    r.rx   = sw;
    r.last = last;
    r.due  = cyc + 1 + (open_cs ? 0 : SU) + 2 * W * DIV;
    open_cs = !last;
    exp_q.push_back(r);
    mosi_q.push_back(d);
    slv_q.push_back(sw);
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    bus_a.tx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rise_pending) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size() + int'(rise_pending), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st, acc, nr, r0, rl;
    logic         prev;
    logic [W-1:0] w;
    bit           lst;

    bus_a.tx_data = '0; bus_a.tx_valid = 1'b0; bus_a.tx_last = 1'b0;
    bus_b.tx_data = '0; bus_b.tx_valid = 1'b0; bus_b.tx_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_cs_n", cs_a, 1);
    chk("rst_sclk", sclk_a, 0);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_rx_valid", bus_a.rx_valid, 0);
    chk("rst_rx_data", bus_a.rx_data, 0);
    chk("rst_ready", bus_a.tx_ready, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_cs_b", cs_b, 1);

    // single word, slave answers 0x5C
    send(8'hAB, 1, 8'h5C);
    drain();
    gap(2);

    // two words under one chip select, tx_valid held
    send(8'hF0, 0, 8'($urandom));
    send(8'h0A, 1, 8'($urandom));
    drain();

    // stall in NEXT, then resume without setup
    send(8'h3C, 0, 8'($urandom));
    drain();
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) begin
        chk("next_cs_n", cs_a, 0);
        chk("next_sclk", sclk_a, 0);
        chk("next_ready", bus_a.tx_ready, 1);
        chk("next_busy", busy_a, 1);
      end
      @(negedge clk);
    end
    send(8'h81, 1, 8'($urandom));
    drain();

    // reset after the third rising edge
    send(8'hFF, 1, 8'($urandom));
    st = rises;
    n = 0;
    while (rises < st + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_edges", rises - st, 3);
    flush = 1;
    rst = 1'b1;
    exp_q.delete();
    mosi_q.delete();
    if (slv_q.size() != 0) void'(slv_q.pop_front());
    open_cs = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cs_n", cs_a, 1);
    chk("abort_sclk", sclk_a, 0);
    chk("abort_ready", bus_a.tx_ready, 1);
    gap(3);
    send(8'h55, 1, 8'($urandom));
    drain();

    // tx inputs churn while the master is busy
    send(8'hC3, 1, 8'($urandom));
    for (int i = 0; i < 60; i++) begin
      bus_a.tx_data  = 8'($urandom);
      bus_a.tx_valid = 1'($urandom);
      bus_a.tx_last  = 1'($urandom);
      chk("busy_not_ready", bus_a.tx_ready, 0);
      @(negedge clk);
    end
    gap(1);
    drain();

    // random traffic
    for (int i = 0; i < 24; i++) begin
      lst = (i == 23) ? 1'b1 : ($urandom_range(0, 2) == 0);
      send(8'($urandom), lst, 8'($urandom));
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 6));
    end
    drain();

    // fast instance, loopback
    for (int k = 0; k < 4; k++) begin
      w = (k == 0) ? 8'h96 : 8'($urandom);
      bus_b.tx_data  = w;
      bus_b.tx_last  = 1'b1;
      bus_b.tx_valid = 1'b1;
      n = 0;
      while (!bus_b.tx_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      acc = cyc;
      @(negedge clk);
      bus_b.tx_valid = 1'b0;
      nr = 0; r0 = 0; rl = 0; prev = 1'b0; n = 0;
      while (!bus_b.rx_valid && n < 60) begin
        if (sclk_b && !prev) begin
          if (nr == 0) r0 = cyc;
          rl = cyc;
          nr++;
        end
        prev = sclk_b;
        @(negedge clk);
        n++;
      end
      chk("b_latency", cyc - acc, 18);
      chk("b_rx_data", bus_b.rx_data, w);
      chk("b_rises", nr, W);
      chk("b_period", rl - r0, 2 * (W - 1));
    end
    gap(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI mode-0 initiator: the master end of the link served by our SPI slave receiver.
- Generates spi_clk, cs_n and mosi from the system clock.
- Shifts out one WIDTH-bit word per handshake, MSB first, and captures miso in parallel.
- Consecutive words stay under one chip-select until a word flagged last completes.

Parameters:
WIDTH, 8, bits per word.
CLK_DIV, 4, clk cycles per spi_clk half-period (>=1).
CS_SETUP, 2, clk cycles cs_n is low before the first spi_clk rising edge (>=1).
CS_HOLD, 2, clk cycles after the final falling edge before cs_n rises (>=1).

Ports:
clk  in  1  system clock; one clock, all logic on rising edge.
rst  in  1  reset, synchronous, active-high.
tx_data  in  WIDTH  word to send; latched on acceptance.
tx_valid  in  1  tx_data/tx_last valid.
tx_last  in  1  release cs_n after this word.
tx_ready  out  1  master can accept a word.
rx_data  out  WIDTH  word captured from miso; held until the next capture.
rx_valid  out  1  one-cycle pulse, rx_data updated.
spi_clk  out  1  serial clock, idle low.
mosi  out  1  serial data out.
miso  in  1  serial data in.
cs_n  out  1  chip select, active low.
busy  out  1  high in every state except IDLE.

Behaviour:
- States:
  - IDLE: cs_n=1, spi_clk=0, tx_ready=1.
  - SETUP: cs_n=0, CS_SETUP cycles.
  - LOW: spi_clk=0, CLK_DIV cycles.
  - HIGH: spi_clk=1, CLK_DIV cycles.
  - NEXT: cs_n=0, spi_clk=0, tx_ready=1.
  - HOLD: cs_n=0, spi_clk=0, CS_HOLD cycles.
- All outputs are registered except tx_ready and busy, which decode from state.
- Reset (sync): state=IDLE, cs_n=1, spi_clk=0, mosi=0, rx_valid=0, rx_data=0, bit counter=0, phase counter=0.
- Accept rule: accept when tx_valid && tx_ready.
  - On acceptance, latch tx_data into the shift register and latch tx_last.
  - mosi takes the MSB on the next cycle.
  - Acceptance in IDLE goes to SETUP; acceptance in NEXT goes directly to LOW (no setup).
- SETUP -> LOW after CS_SETUP cycles. LOW -> HIGH after CLK_DIV cycles.
- On the clk edge ending each HIGH phase:
  - sample miso into the shift-register LSB;
  - shift left, so mosi presents the next bit as spi_clk falls;
  - increment the bit counter.
- After the WIDTH-th HIGH phase:
  - rx_data <= captured word; rx_valid=1 for exactly the next cycle;
  - go to HOLD if the latched last flag is set, else NEXT.
- NEXT waits indefinitely with cs_n low and spi_clk low. tx_ready=1 only in IDLE and NEXT.
- HOLD -> IDLE after CS_HOLD cycles; cs_n rises on entering IDLE.
  - IDLE lasts at least one cycle with cs_n high before any new SETUP, even if tx_valid is already high.
- Latency: acceptance in IDLE at cycle 0 gives rx_valid at cycle 1+CS_SETUP+2*WIDTH*CLK_DIV (67 with defaults).
  - Back-to-back words in NEXT: 1+2*WIDTH*CLK_DIV cycles from acceptance to rx_valid.
- tx_data and tx_valid changes while not ready are ignored.
- mosi holds its last driven value outside transfers.
- Reset mid-transfer: next cycle cs_n=1, spi_clk=0, no rx_valid pulse; partial data is discarded.
- Counters: the phase counter is sized for max(CLK_DIV, CS_SETUP, CS_HOLD); the bit counter is clog2(WIDTH+1) bits. Neither may wrap within a phase.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE, SETUP, LOW, HIGH, NEXT, HOLD);
  - SPI mode constants (CPOL=0, CPHA=0, MSB_FIRST=1), shared with the slave receiver.
- One natural sub-module: spi_phase_counter.
  - Loadable down-counter; emits a terminal pulse.
  - Reused for SETUP, half-periods and HOLD.

Test Plan:
- tx_data=0xAB, tx_last=1, miso driven by a mode-0 slave model returning 0x5C -> mosi at the 8 rising edges = 1,0,1,0,1,0,1,1; rx_data=0x5C with rx_valid at cycle 67; cs_n rises 2 cycles after the last falling edge.
- Loopback mosi->miso, words 0xF0 (last=0) then 0x0A (last=1), tx_valid held -> cs_n low throughout; 16 rising edges; no SETUP gap; rx_valid pulses 65 cycles apart with 0xF0, then 0x0A.
- Word 0x3C last=0, then tx_valid low for 20 cycles -> cs_n=0, spi_clk=0, tx_ready=1, busy=1 throughout; next word 0x81 resumes without SETUP.
- rst asserted after 3 rising edges of word 0xFF -> next cycle cs_n=1, spi_clk=0, tx_ready=1; no rx_valid; a following 0x55 transfer is correct.
- tx_data toggled every cycle during a 0xC3 transfer -> mosi sequence matches 0xC3 only; tx_ready stays 0 until NEXT/IDLE.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, loopback 0x96 -> spi_clk period 2 clk cycles; rx_valid at cycle 18; rx_data=0x96.
